// File: rtl/pcileech_rst_ctl.sv
// pcileech_rst_ctl: reset and user-button sequencer for the board top level.
// Synchronizes and debounces the two user buttons, sequences the system
// reset with a minimum hold, detects a long SW2 press as a config-reload
// request, and sources the 64-bit tick count and the power-on LED blink.
// Optional feature macro: PCILEECH_RST_PERST_EN (PCIe PERST# resets the system).
//
// state  | meaning
// HOLD   | rst_sys asserted, counting the minimum hold time
// RUN    | system running, rst_sys released
// PRESS  | SW2 held, rst_sys asserted, counting towards config reload
// RELOAD | SW2 held long enough, rst_cfg_reload asserted until release
// PERST  | PCIe PERST# low, rst_sys asserted until it deasserts
module pcileech_rst_ctl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned RST_HOLD_CYCLES = 64,
  parameter int unsigned RELOAD_CYCLES   = 500000000,
  parameter int unsigned BLINK_BIT       = 24,
  parameter int unsigned BLINK_LIMIT_BIT = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        user_sw1_n,
  input  logic        user_sw2_n,
  input  logic        pcie_perst_n,
  output logic        rst_sys,
  output logic        rst_com_n,
  output logic        rst_cfg_reload,
  output logic        led_pwronblink,
  output logic [63:0] tickcount64
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam int PRS_W  = (RELOAD_CYCLES > 1)   ? $clog2(RELOAD_CYCLES)   : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [PRS_W-1:0]  PRS_LAST  = PRS_W'(RELOAD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_RUN    = 3'd1,
    ST_PRESS  = 3'd2,
    ST_RELOAD = 3'd3,
    ST_PERST  = 3'd4
  } state_t;

  // bit 0 = SW1, bit 1 = SW2, bit 2 = PERST#; all idle high
  logic [2:0]            sync_s1_q, sync_s1_d;
  logic [2:0]            sync_s2_q, sync_s2_d;
  logic [1:0]            stable_q, stable_d;
  logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

  state_t                state_q, state_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [PRS_W-1:0]      press_cnt_q, press_cnt_d;

  logic                  rst_sys_q, rst_sys_d;
  logic                  rst_com_n_q, rst_com_n_d;
  logic                  reload_q, reload_d;
  logic                  led_q, led_d;
  logic [63:0]           tick_q, tick_d;

  logic                  sw1_p, sw2_p, perst_s;

  assign sw1_p   = ~stable_q[0];
  assign sw2_p   = ~stable_q[1];
  assign perst_s = sync_s2_q[2];

  // Two-flop synchronizers for the raw asynchronous inputs
  always_comb begin
    sync_s1_d = {pcie_perst_n, user_sw2_n, user_sw1_n};
    sync_s2_d = sync_s1_q;
  end

  // Per-button debounce: accept a change only after DEBOUNCE_CYCLES stable cycles
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync_s2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Next-state logic; SW2 always takes priority over PERST#
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: begin
        if (sw2_p)                         state_d = ST_PRESS;
        else if (hold_cnt_q == HOLD_LAST)  state_d = ST_RUN;
      end
      ST_RUN: begin
        if (sw2_p)                         state_d = ST_PRESS;
`ifdef PCILEECH_RST_PERST_EN
        else if (!perst_s)                 state_d = ST_PERST;
`endif
      end
      ST_PRESS: begin
        if (!sw2_p)                        state_d = ST_HOLD;
        else if (press_cnt_q == PRS_LAST)  state_d = ST_RELOAD;
      end
      ST_RELOAD: begin
        if (!sw2_p)                        state_d = ST_HOLD;
      end
      ST_PERST: begin
        if (sw2_p)                         state_d = ST_PRESS;
        else if (perst_s)                  state_d = ST_HOLD;
      end
      default:                             state_d = ST_HOLD;
    endcase
  end

  // Counters and registered outputs, all derived from the next state so the
  // outputs change on the same edge as the state
  always_comb begin
    hold_cnt_d  = '0;
    press_cnt_d = '0;
    if (state_q == ST_HOLD && state_d == ST_HOLD) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
    if (state_q == ST_PRESS && state_d == ST_PRESS) begin
      press_cnt_d = (press_cnt_q == '1) ? press_cnt_q : press_cnt_q + 1'b1;
    end

    rst_sys_d   = (state_d != ST_RUN);
    rst_com_n_d = (state_d == ST_RUN);
    reload_d    = (state_d == ST_RELOAD);

    if (state_d == ST_PRESS || state_d == ST_RELOAD) begin
      tick_d = '0;
    end else begin
      tick_d = tick_q + 64'd1;
    end

    led_d = sw1_p ^ (tick_q[BLINK_BIT] & (tick_q[63:BLINK_LIMIT_BIT] == '0));
  end

  // Synchronizer and debounce registers; idle (released) level on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_s1_q <= '1;
      sync_s2_q <= '1;
      stable_q  <= '1;
      db_cnt_q  <= '0;
    end else begin
      sync_s1_q <= sync_s1_d;
      sync_s2_q <= sync_s2_d;
      stable_q  <= stable_d;
      db_cnt_q  <= db_cnt_d;
    end
  end

  // FSM state, counters and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      press_cnt_q <= '0;
      rst_sys_q   <= 1'b1;
      rst_com_n_q <= 1'b0;
      reload_q    <= 1'b0;
      led_q       <= 1'b0;
      tick_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      press_cnt_q <= press_cnt_d;
      rst_sys_q   <= rst_sys_d;
      rst_com_n_q <= rst_com_n_d;
      reload_q    <= reload_d;
      led_q       <= led_d;
      tick_q      <= tick_d;
    end
  end

  assign rst_sys        = rst_sys_q;
  assign rst_com_n      = rst_com_n_q;
  assign rst_cfg_reload = reload_q;
  assign led_pwronblink = led_q;
  assign tickcount64    = tick_q;

endmodule
